// File: rtl/bgd_tile_controller.sv
// Background tile grid controller.
// Tracks which tiles of a COLS x ROWS grid of 32x32 tiles are still alive,
// tells the drawing path whether the current pixel sits on a live tile (and
// where inside the tile), and applies collision kills / full restores only at
// frame boundaries so the picture never changes mid-frame.
module bgd_tile_controller #(
    parameter int TOP_LEFT_X = 0,
    parameter int TOP_LEFT_Y = 352,
    parameter int COLS       = 20,
    parameter int ROWS       = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        hitReq,
    input  logic        restoreAll,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        insideRectangle,
    output logic [6:0]  tilesLeft,
    output logic        allCleared
);

    localparam int NUM_TILES = COLS * ROWS;

    localparam logic [11:0] X_LO        = 12'(TOP_LEFT_X);
    localparam logic [11:0] Y_LO        = 12'(TOP_LEFT_Y);
    localparam logic [11:0] GRID_W      = 12'(32 * COLS);
    localparam logic [11:0] GRID_H      = 12'(32 * ROWS);
    localparam logic [11:0] COLS_W      = 12'(COLS);
    localparam logic [6:0]  TOTAL_TILES = 7'(NUM_TILES);

    localparam logic [NUM_TILES-1:0] ONE_HOT  = {{(NUM_TILES-1){1'b0}}, 1'b1};
    localparam logic [NUM_TILES-1:0] ALL_LIVE = {NUM_TILES{1'b1}};

    // Number of set bits in a tile map, clamped to the grid size.
    function automatic logic [6:0] count_live(input logic [NUM_TILES-1:0] map);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < NUM_TILES; i++) begin
            cnt = cnt + {7'd0, map[i]};
        end
        if (cnt > {1'b0, TOTAL_TILES}) begin
            return TOTAL_TILES;
        end else begin
            return cnt[6:0];
        end
    endfunction

    // State and registered outputs
    logic [NUM_TILES-1:0] active_q, active_d;
    logic [NUM_TILES-1:0] pending_q, pending_d;
    logic                 restore_q, restore_d;
    logic                 inside_q, inside_d;
    logic [10:0]          offset_x_q, offset_x_d;
    logic [10:0]          offset_y_q, offset_y_d;
    logic [6:0]           tiles_left_q, tiles_left_d;

    // Pixel decode signals
    logic [12:0]          dx_s, dy_s;
    logic                 in_grid_s;
    logic [11:0]          col_s, row_s, idx_s;
    logic [NUM_TILES-1:0] tile_mask_s;
    logic                 tile_live_s;
    logic                 tile_pending_s;
    logic                 hit_ok_s;

    // Locate the current pixel in the grid; a borrow out of the 13-bit
    // difference means the pixel lies left of / above the grid.
    always_comb begin
        dx_s      = {2'b00, pixelX} - {1'b0, X_LO};
        dy_s      = {2'b00, pixelY} - {1'b0, Y_LO};
        in_grid_s = !dx_s[12] && (dx_s[11:0] < GRID_W) &&
                    !dy_s[12] && (dy_s[11:0] < GRID_H);
        col_s     = {5'd0, dx_s[11:5]};
        row_s     = {5'd0, dy_s[11:5]};
        idx_s     = row_s * COLS_W + col_s;
        if (in_grid_s) begin
            tile_mask_s = ONE_HOT << idx_s;
        end else begin
            tile_mask_s = '0;
        end
        tile_live_s    = |(active_q & tile_mask_s);
        tile_pending_s = |(pending_q & tile_mask_s);
        hit_ok_s       = hitReq && tile_live_s && !tile_pending_s;
    end

    // Next-state: record hits as pending kills, commit or restore at frame start.
    always_comb begin
        active_d     = active_q;
        pending_d    = pending_q;
        restore_d    = restore_q;
        tiles_left_d = tiles_left_q;
        if (startOfFrame) begin
            // Commit uses the pre-hit pending map; a coincident hit starts the
            // new frame's pending map, a coincident restore waits a frame.
            if (restore_q) begin
                active_d = ALL_LIVE;
            end else begin
                active_d = active_q & ~pending_q;
            end
            if (hit_ok_s) begin
                pending_d = tile_mask_s;
            end else begin
                pending_d = '0;
            end
            restore_d    = restoreAll;
            tiles_left_d = count_live(active_d);
        end else begin
            if (hit_ok_s) begin
                pending_d = pending_q | tile_mask_s;
            end else begin
                pending_d = pending_q;
            end
            if (restoreAll) begin
                restore_d = 1'b1;
            end else begin
                restore_d = restore_q;
            end
        end
    end

    // Next values of the pixel-path outputs; offsets forced to 0 off live tiles.
    always_comb begin
        inside_d = tile_live_s;
        if (tile_live_s) begin
            offset_x_d = {6'd0, dx_s[4:0]};
            offset_y_d = {6'd0, dy_s[4:0]};
        end else begin
            offset_x_d = 11'd0;
            offset_y_d = 11'd0;
        end
    end

    // All state and registered outputs; reset revives every tile and drops
    // any pending kills or restore request.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active_q     <= ALL_LIVE;
            pending_q    <= '0;
            restore_q    <= 1'b0;
            inside_q     <= 1'b0;
            offset_x_q   <= 11'd0;
            offset_y_q   <= 11'd0;
            tiles_left_q <= TOTAL_TILES;
        end else begin
            active_q     <= active_d;
            pending_q    <= pending_d;
            restore_q    <= restore_d;
            inside_q     <= inside_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
            tiles_left_q <= tiles_left_d;
        end
    end

    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign insideRectangle = inside_q;
    assign tilesLeft       = tiles_left_q;
    assign allCleared      = (tiles_left_q == 7'd0);

endmodule

// File: tb/tb_bgd_tile_controller.sv
// Self-checking bench for bgd_tile_controller: directed scenarios followed by
// randomized pixels/hits/frames checked against a 2-D array model of the grid.
module tb_bgd_tile_controller;

    localparam int TLX  = 0;
    localparam int TLY  = 352;
    localparam int COLS = 20;
    localparam int ROWS = 4;
    localparam int NT   = COLS * ROWS;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hitReq, restoreAll;
    logic [10:0] offsetX, offsetY;
    logic        insideRectangle;
    logic [6:0]  tilesLeft;
    logic        allCleared;

    int total = 0;
    int bad   = 0;

    // reference model
    bit live [ROWS][COLS];
    bit pend [ROWS][COLS];
    bit rflag;
    int m_tiles;

    bgd_tile_controller #(
        .TOP_LEFT_X(TLX), .TOP_LEFT_Y(TLY), .COLS(COLS), .ROWS(ROWS)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .hitReq(hitReq), .restoreAll(restoreAll),
        .offsetX(offsetX), .offsetY(offsetY), .insideRectangle(insideRectangle),
        .tilesLeft(tilesLeft), .allCleared(allCleared)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int count_model();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                n += live[r][c] ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                live[r][c] = 1'b1;
                pend[r][c] = 1'b0;
            end
        rflag   = 1'b0;
        m_tiles = NT;
    endtask

    // One clock: apply inputs, advance the model, compare all outputs after the edge.
    task automatic step(input int x, input int y, input bit sof, input bit hit, input bit rall);
        bit in;
        int c, r, ex_in, ex_ox, ex_oy;
        bit hit_ok;
        pixelX = 11'(x); pixelY = 11'(y);
        startOfFrame = sof; hitReq = hit; restoreAll = rall;
        in = (x >= TLX) && (x < TLX + 32*COLS) && (y >= TLY) && (y < TLY + 32*ROWS);
        c = in ? (x - TLX) / 32 : 0;
        r = in ? (y - TLY) / 32 : 0;
        ex_in  = (in && live[r][c]) ? 1 : 0;
        ex_ox  = (ex_in == 1) ? (x - TLX) % 32 : 0;
        ex_oy  = (ex_in == 1) ? (y - TLY) % 32 : 0;
        hit_ok = hit && in && live[r][c] && !pend[r][c];
        if (sof) begin
            for (int rr = 0; rr < ROWS; rr++)
                for (int cc = 0; cc < COLS; cc++) begin
                    live[rr][cc] = rflag ? 1'b1 : (live[rr][cc] && !pend[rr][cc]);
                    pend[rr][cc] = 1'b0;
                end
            if (hit_ok) pend[r][c] = 1'b1;
            rflag   = rall;
            m_tiles = count_model();
        end else begin
            if (hit_ok) pend[r][c] = 1'b1;
            if (rall) rflag = 1'b1;
        end
        @(posedge clk); #1;
        chk("inside",  insideRectangle, ex_in);
        chk("offsetX", offsetX, ex_ox);
        chk("offsetY", offsetY, ex_oy);
        chk("tiles",   tilesLeft, m_tiles);
        chk("cleared", allCleared, (m_tiles == 0) ? 1 : 0);
    endtask

    // Assert reset away from the clock edge, check outputs while held, release.
    task automatic do_reset();
        startOfFrame = 1'b0; hitReq = 1'b0; restoreAll = 1'b0;
        pixelX = 11'd5; pixelY = 11'd353;
        resetN = 1'b0;
        model_reset();
        #1;
        chk("rst_inside", insideRectangle, 0);
        chk("rst_offx",   offsetX, 0);
        chk("rst_offy",   offsetY, 0);
        chk("rst_tiles",  tilesLeft, NT);
        chk("rst_clr",    allCleared, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_inside", insideRectangle, 0);
        chk("rst_hold_tiles",  tilesLeft, NT);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b1;
        pixelX = 11'd0; pixelY = 11'd0;
        startOfFrame = 1'b0; hitReq = 1'b0; restoreAll = 1'b0;
        model_reset();
        #2;
        do_reset();

        // first pixel on the grid, then one outside
        step(5, 353, 0, 0, 0);
        chk("r37_in", insideRectangle, 1);
        chk("r37_ox", offsetX, 5);
        chk("r37_oy", offsetY, 1);
        chk("r37_tl", tilesLeft, 80);
        step(100, 200, 0, 0, 0);
        chk("r38_in", insideRectangle, 0);

        // kill tile (1,0) twice, stays visible until the frame ends
        step(40, 360, 0, 1, 0);
        step(41, 361, 0, 1, 0);
        chk("r39_still_in", insideRectangle, 1);
        step(45, 370, 0, 0, 0);
        chk("r39_frame_in", insideRectangle, 1);
        step(0, 0, 1, 0, 0);
        chk("r39_tl", tilesLeft, 79);
        step(40, 360, 0, 0, 0);
        chk("r39_dead", insideRectangle, 0);

        // hit coinciding with frame start
        do_reset();
        step(0, 352, 1, 1, 0);
        chk("r40_same", tilesLeft, 80);
        step(0, 352, 0, 0, 0);
        chk("r40_vis", insideRectangle, 1);
        step(0, 0, 1, 0, 0);
        chk("r40_next", tilesLeft, 79);

        // kill everything, then restore
        do_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                step(TLX + c*32 + 7, TLY + r*32 + 9, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("r41_clr", allCleared, 1);
        chk("r41_tl",  tilesLeft, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("r41_rest_tl",  tilesLeft, 80);
        chk("r41_rest_clr", allCleared, 0);

        // restore coinciding with frame start waits one more frame
        step(7, 360, 0, 1, 0);
        step(0, 0, 1, 0, 1);
        chk("r31_commit", tilesLeft, 79);
        step(0, 0, 1, 0, 0);
        chk("r31_restore", tilesLeft, 80);

        // pending kill discarded by reset
        do_reset();
        step(67, 387, 0, 1, 0);
        do_reset();
        step(0, 0, 1, 0, 0);
        chk("r42_tl", tilesLeft, 80);
        step(67, 387, 0, 0, 0);
        chk("r42_live", insideRectangle, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 1500) == 0) do_reset();
            step($urandom_range(0, 700), $urandom_range(330, 500),
                 (i % 50) == 49, ($urandom % 4) == 0, ($urandom % 200) == 0);
        end

        startOfFrame = 1'b0; hitReq = 1'b0; restoreAll = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bgd_tile_controller.md
BGD_TILE_CONTROLLER -- requirements
Module: bgd_tile_controller

Interface
REQ-001 The block SHALL have a parameter TOP_LEFT_X, default 0, giving the grid left edge in pixels.
REQ-002 The block SHALL have a parameter TOP_LEFT_Y, default 352, giving the grid top edge in pixels.
REQ-003 The block SHALL have a parameter COLS, default 20, giving the number of tile columns.
REQ-004 The block SHALL have a parameter ROWS, default 4, giving the number of tile rows.
REQ-005 The block SHALL use a fixed tile size of 32x32 pixels.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock.
REQ-007 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port pixelX, input, 11 bits: current VGA column.
REQ-009 The block SHALL have port pixelY, input, 11 bits: current VGA row.
REQ-010 The block SHALL have port startOfFrame, input, 1 bit: one-cycle pulse at frame start.
REQ-011 The block SHALL have port hitReq, input, 1 bit: collision pulse that kills the tile under the current pixel.
REQ-012 The block SHALL have port restoreAll, input, 1 bit: pulse requesting that all tiles be revived.
REQ-013 The block SHALL have port offsetX, output, 11 bits: pixel offset inside the tile, to the bitmap.
REQ-014 The block SHALL have port offsetY, output, 11 bits: pixel offset inside the tile, to the bitmap.
REQ-015 The block SHALL have port insideRectangle, output, 1 bit: current pixel is on a live tile.
REQ-016 The block SHALL have port tilesLeft, output, 7 bits: count of live tiles.
REQ-017 The block SHALL have port allCleared, output, 1 bit: high when tilesLeft == 0.

Function
REQ-018 The block SHALL hold a live map of COLS*ROWS bits (the active map) and a pending-kill map of the same size.
REQ-019 A pixel SHALL be in the grid iff TOP_LEFT_X <= pixelX < TOP_LEFT_X+32*COLS and TOP_LEFT_Y <= pixelY < TOP_LEFT_Y+32*ROWS.
REQ-020 Column SHALL equal (pixelX-TOP_LEFT_X)>>5 and row SHALL equal (pixelY-TOP_LEFT_Y)>>5.
REQ-021 offsetX SHALL be (pixelX-TOP_LEFT_X)&31 and offsetY SHALL be (pixelY-TOP_LEFT_Y)&31, each zero-extended to 11 bits.
REQ-022 offsetX, offsetY and insideRectangle SHALL be registered with exactly 1 clk of latency from pixelX/pixelY.
REQ-023 insideRectangle SHALL be 1 only when the pixel is in the grid and its active-map bit is 1.
REQ-024 When insideRectangle is 0, offsetX and offsetY SHALL be 0.
REQ-025 A hitReq with the current pixel on a live tile SHALL set that tile's pending bit; the active map SHALL NOT change mid-frame.
REQ-026 A hitReq outside the grid, or on a dead or already-pending tile, SHALL be ignored.
REQ-027 On startOfFrame, the active map SHALL become active & ~pending, the pending map SHALL clear, and tilesLeft SHALL update in the same cycle.
REQ-028 A restoreAll pulse SHALL latch a restore flag.
REQ-029 At the next startOfFrame with the restore flag set: the active map SHALL become all ones, pending and the flag SHALL clear, and tilesLeft SHALL become COLS*ROWS; restore SHALL take priority over pending kills.
REQ-030 When hitReq and startOfFrame coincide, the commit SHALL use the pre-hit pending map, and the hit SHALL be recorded into the new pending map.
REQ-031 When restoreAll and startOfFrame coincide, the restore SHALL apply at the following startOfFrame.
REQ-032 tilesLeft SHALL be a registered count, never wrap below 0, and saturate at COLS*ROWS.
REQ-033 allCleared SHALL be asserted combinationally from the registered tilesLeft.

Reset
REQ-034 While resetN is low: active map SHALL be all ones; pending map and restore flag SHALL be 0.
REQ-035 While resetN is low: offsetX = offsetY = 0, insideRectangle = 0, tilesLeft = COLS*ROWS (80), allCleared = 0.
REQ-036 Reset asserted mid-frame SHALL discard all pending kills and any pending restore.

Verification
REQ-037 Reset, then scan pixel (5,353) -> one cycle later insideRectangle=1, offsetX=5, offsetY=1; tilesLeft=80.
REQ-038 Pixel (100,200), outside the grid -> insideRectangle=0, offsets 0.
REQ-039 hitReq at (40,360), then hitReq at (41,361) -> insideRectangle stays 1 for tile (1,0) for the rest of the frame; at next startOfFrame tilesLeft=79; next frame pixel (40,360) gives insideRectangle=0.
REQ-040 hitReq coinciding with startOfFrame at (0,352) -> tilesLeft unchanged that cycle; becomes 79 one frame later.
REQ-041 Kill all 80 tiles -> after commit allCleared=1, tilesLeft=0; restoreAll then startOfFrame -> tilesLeft=80, allCleared=0.
REQ-042 Pending kill on tile (2,1), then resetN low mid-frame -> after reset and next startOfFrame tilesLeft=80 and tile (2,1) still live.
